// File: rtl/data_mem_arbiter_pkg.sv
// Shared types and helpers for the two-requester data memory arbiter.
package data_mem_arb_pkg;

  localparam int unsigned DEPTH_WORDS_DEF = 64;

  typedef enum logic {PREF0 = 1'b0, PREF1 = 1'b1} arb_state_e;

  // Callers zero-extend the address to 64 bits so one helper serves any DATA_W <= 64.
  function automatic logic addr_bad(input logic [63:0] addr, input int unsigned depth);
    return (addr[1:0] != 2'b00) || (addr[63:2] >= 62'(depth));
  endfunction

endpackage

// File: rtl/data_mem_arbiter_if.sv
// Requester, response and memory-side signals of the arbiter bundled as one interface.
interface data_mem_arbiter_if #(parameter int DATA_W = 32);
  logic              req0_valid, req0_ready, req0_we;
  logic [DATA_W-1:0] req0_addr, req0_wdata;
  logic              req1_valid, req1_ready, req1_we;
  logic [DATA_W-1:0] req1_addr, req1_wdata;
  logic              rsp0_valid, rsp0_err;
  logic [DATA_W-1:0] rsp0_rdata;
  logic              rsp1_valid, rsp1_err;
  logic [DATA_W-1:0] rsp1_rdata;
  logic [DATA_W-1:0] mem_addr, mem_wdata, mem_rdata;
  logic              mem_we;

  modport slave (
    input  req0_valid, req0_we, req0_addr, req0_wdata,
    input  req1_valid, req1_we, req1_addr, req1_wdata, mem_rdata,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_err, rsp0_rdata, rsp1_valid, rsp1_err, rsp1_rdata,
    output mem_addr, mem_wdata, mem_we
  );

  modport master (
    output req0_valid, req0_we, req0_addr, req0_wdata,
    output req1_valid, req1_we, req1_addr, req1_wdata, mem_rdata,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_err, rsp0_rdata, rsp1_valid, rsp1_err, rsp1_rdata,
    input  mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/data_mem_arbiter_rr_arb2.sv
// Two-input round-robin grant logic with its preference FSM.
module rr_arb2
  import data_mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] valid_i,
  output logic [1:0] gnt_o
);

  arb_state_e state_q, state_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= PREF0;
    else        state_q <= state_d;
  end

  always_comb begin
    gnt_o   = valid_i;
    state_d = state_q;
    if (&valid_i) gnt_o = (state_q == PREF0) ? 2'b01 : 2'b10;
    // Preference flips to whoever was not just served; idle cycles keep it.
    if (gnt_o[0])      state_d = PREF1;
    else if (gnt_o[1]) state_d = PREF0;
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares one single-port data memory between two requesters, one transaction per cycle.
module data_mem_arbiter
  import data_mem_arb_pkg::*;
#(
  parameter int          DATA_W      = 32,
  parameter int unsigned DEPTH_WORDS = DEPTH_WORDS_DEF
) (
  input logic              clk,
  input logic              rst_n,
  data_mem_arbiter_if.slave bus
);

  logic [1:0]        vld, gnt;
  logic              g_any, g_bad, g_we, mem_ok;
  logic [DATA_W-1:0] g_addr, g_wdata;

  // Valids are masked by reset so nothing combinational leaks out while held in reset.
  assign vld = {bus.req1_valid, bus.req0_valid} & {2{rst_n}};

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid_i (vld),
    .gnt_o   (gnt)
  );

  always_comb begin
    g_any   = |gnt;
    g_we    = gnt[1] ? bus.req1_we    : bus.req0_we;
    g_addr  = gnt[1] ? bus.req1_addr  : bus.req0_addr;
    g_wdata = gnt[1] ? bus.req1_wdata : bus.req0_wdata;
    g_bad   = g_any && addr_bad(64'(g_addr), DEPTH_WORDS);
    mem_ok  = g_any && !g_bad;
  end

  assign bus.req0_ready = gnt[0];
  assign bus.req1_ready = gnt[1];
  assign bus.mem_addr   = mem_ok ? g_addr  : '0;
  assign bus.mem_wdata  = mem_ok ? g_wdata : '0;
  assign bus.mem_we     = mem_ok && g_we;

  logic [1:0]        rsp_vld_q, rsp_vld_d;
  logic              rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

  always_comb begin
    rsp_vld_d   = gnt;
    rsp_err_d   = g_bad;
    rsp_rdata_d = (mem_ok && !g_we) ? bus.mem_rdata : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_vld_q   <= '0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_vld_q   <= rsp_vld_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // Only one response is ever in flight, so both requesters share the payload registers.
  assign bus.rsp0_valid = rsp_vld_q[0];
  assign bus.rsp1_valid = rsp_vld_q[1];
  assign bus.rsp0_err   = rsp_vld_q[0] & rsp_err_q;
  assign bus.rsp1_err   = rsp_vld_q[1] & rsp_err_q;
  assign bus.rsp0_rdata = rsp_vld_q[0] ? rsp_rdata_q : '0;
  assign bus.rsp1_rdata = rsp_vld_q[1] ? rsp_rdata_q : '0;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Scoreboard bench: drivers issue requests, a negedge monitor checks grants, memory side and responses.
module tb_data_mem_arbiter;
  localparam int DW    = 32;
  localparam int DEPTH = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  data_mem_arbiter_if #(.DATA_W(DW)) bus();

  data_mem_arbiter #(.DATA_W(DW), .DEPTH_WORDS(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Memory device attached to the arbiter, plus the bench's independent view of its contents.
  logic [DW-1:0] dev_mem [DEPTH];
  logic [DW-1:0] ref_mem [DEPTH];
  assign bus.mem_rdata = dev_mem[bus.mem_addr[7:2]];
  always @(posedge clk) if (bus.mem_we) dev_mem[bus.mem_addr[7:2]] <= bus.mem_wdata;

  typedef struct { logic [DW-1:0] rdata; logic err; } rsp_t;
  rsp_t q0[$];
  rsp_t q1[$];

  int n_tests = 0;
  int n_fail  = 0;
  bit due [2];
  int pref = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: responses due from last cycle's grant, then this cycle's grant and memory outputs.
  logic [1:0]    m_v, m_exp;
  logic [DW-1:0] m_a, m_wd, m_rd;
  logic          m_we, m_rv, m_er, m_bad;
  rsp_t          m_e, m_got;
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("reset_outputs", {bus.req0_ready, bus.req1_ready, bus.rsp0_valid, bus.rsp1_valid,
          bus.rsp0_err, bus.rsp1_err, bus.mem_we, |bus.mem_addr, |bus.mem_wdata,
          |bus.rsp0_rdata, |bus.rsp1_rdata}, 64'd0);
      q0.delete(); q1.delete();
      due[0] = 1'b0; due[1] = 1'b0;
      pref = 0;
    end else begin
      for (int n = 0; n < 2; n++) begin
        m_rv = n ? bus.rsp1_valid : bus.rsp0_valid;
        m_rd = n ? bus.rsp1_rdata : bus.rsp0_rdata;
        m_er = n ? bus.rsp1_err   : bus.rsp0_err;
        chk($sformatf("rsp%0d_valid", n), m_rv, due[n]);
        if (m_rv) begin
          if ((n ? q1.size() : q0.size()) == 0) begin
            n_tests++; n_fail++;
            $display("FAIL rsp%0d_unexpected: got a response, expected none queued", n);
          end else begin
            m_got = n ? q1.pop_front() : q0.pop_front();
            chk($sformatf("rsp%0d_rdata", n), m_rd, m_got.rdata);
            chk($sformatf("rsp%0d_err", n), m_er, m_got.err);
          end
        end else begin
          chk($sformatf("rsp%0d_idle_zero", n), {m_er, m_rd}, 64'd0);
        end
      end
      m_v   = {bus.req1_valid, bus.req0_valid};
      m_exp = (m_v == 2'b11) ? ((pref == 0) ? 2'b01 : 2'b10) : m_v;
      chk("grant", {bus.req1_ready, bus.req0_ready}, m_exp);
      due[0] = m_exp[0]; due[1] = m_exp[1];
      if (m_exp != 2'b00) begin
        m_a   = m_exp[1] ? bus.req1_addr  : bus.req0_addr;
        m_wd  = m_exp[1] ? bus.req1_wdata : bus.req0_wdata;
        m_we  = m_exp[1] ? bus.req1_we    : bus.req0_we;
        m_bad = (m_a[1:0] != 2'b00) || ((m_a >> 2) >= DEPTH);
        chk("mem_addr",  bus.mem_addr,  m_bad ? '0 : m_a);
        chk("mem_wdata", bus.mem_wdata, m_bad ? '0 : m_wd);
        chk("mem_we",    bus.mem_we,    !m_bad && m_we);
        m_e.err   = m_bad;
        m_e.rdata = (m_bad || m_we) ? '0 : ref_mem[m_a >> 2];
        if (!m_bad && m_we) ref_mem[m_a >> 2] = m_wd;
        if (m_exp[1]) q1.push_back(m_e); else q0.push_back(m_e);
        pref = m_exp[1] ? 0 : 1;
      end else begin
        chk("mem_idle_zero", {bus.mem_we, bus.mem_addr, bus.mem_wdata}, 64'd0);
      end
    end
  end

  task automatic set_req(input int n, input bit v, input bit we,
                         input logic [DW-1:0] a, input logic [DW-1:0] wd);
    if (n == 0) begin
      bus.req0_valid = v; bus.req0_we = we; bus.req0_addr = a; bus.req0_wdata = wd;
    end else begin
      bus.req1_valid = v; bus.req1_we = we; bus.req1_addr = a; bus.req1_wdata = wd;
    end
  endtask

  // Present one transaction, hold it until ready, release it just after the accepting edge.
  task automatic xfer(input int n, input bit we, input logic [DW-1:0] a, input logic [DW-1:0] wd);
    int cyc = 0;
    bit got = 1'b0;
    set_req(n, 1'b1, we, a, wd);
    while (!got && cyc < 2) begin
      @(negedge clk);
      got = n ? bus.req1_ready : bus.req0_ready;
      cyc++;
    end
    if (!got) begin
      n_tests++; n_fail++;
      $display("FAIL req%0d_wait: no ready after %0d cycles, required within 2", n, cyc);
    end
    @(posedge clk); #1;
    set_req(n, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic rand_stream(input int n, input int count);
    logic [DW-1:0] a;
    int r;
    for (int i = 0; i < count; i++) begin
      r = $urandom_range(0, 9);
      if (r < 7)       a = DW'($urandom_range(0, 7)) << 2;
      else if (r == 7) a = (DW'($urandom_range(0, 63)) << 2) + DW'($urandom_range(1, 3));
      else if (r == 8) a = DW'($urandom_range(64, 300)) << 2;
      else             a = $urandom | 32'h0001_0000;
      xfer(n, 1'($urandom_range(0, 1)), a, $urandom);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      dev_mem[i] = $urandom;
      ref_mem[i] = dev_mem[i];
    end
    // Requests asserted during reset must see no ready and no memory activity.
    set_req(0, 1'b1, 1'b1, 32'h10, 32'h55);
    set_req(1, 1'b1, 1'b0, 32'h14, 32'h0);
    repeat (3) @(negedge clk);
    @(posedge clk); #2;
    rst_n = 1'b1;
    // Continuous reads from both right out of reset: grants alternate 0,1,0,1.
    fork
      begin xfer(0, 1'b0, 32'h0, '0); xfer(0, 1'b0, 32'h10, '0); end
      begin xfer(1, 1'b0, 32'h4, '0); xfer(1, 1'b0, 32'h14, '0); end
    join
    @(posedge clk); #1;
    xfer(0, 1'b1, 32'h8, 32'd99);
    xfer(1, 1'b0, 32'h6, '0);
    xfer(1, 1'b0, 32'h100, '0);
    xfer(0, 1'b1, 32'h4, 32'd15);
    xfer(0, 1'b0, 32'h4, '0);
    @(posedge clk); #1;
    // Reset in the cycle after a read grant kills that response.
    set_req(0, 1'b1, 1'b0, 32'hC, '0);
    @(posedge clk); #1;
    set_req(0, 1'b1, 1'b0, 32'h18, '0);
    set_req(1, 1'b1, 1'b0, 32'h1C, '0);
    rst_n = 1'b0;
    #1;
    chk("reset_kills_rsp0", {bus.rsp0_valid, bus.rsp0_rdata}, 64'd0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    chk("first_grant_after_reset", {bus.req1_ready, bus.req0_ready}, 64'd1);
    @(posedge clk); #1;
    set_req(0, 1'b0, 1'b0, '0, '0);
    @(posedge clk); #1;
    set_req(1, 1'b0, 1'b0, '0, '0);
    fork
      rand_stream(0, 60);
      rand_stream(1, 60);
    join
    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", q0.size() + q1.size(), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
